// File: rtl/spi_mem_pkg.sv
// Shared constants and state encoding for the
// SPI memory responder.
package spi_mem_pkg;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    localparam int ADDR_PHASE_BITS = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_READ,
        ST_WRITE,
        ST_IGNORE
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronisers for the SPI pins plus
// sclk edge detection in the clk domain.
module spi_sync_edge (
    input  logic clk,
    input  logic sclk,
    input  logic mosi,
    input  logic cs_n,
    output logic mosi_s,
    output logic cs_n_s,
    output logic rise_evt,
    output logic fall_evt
);

    logic [2:0] r_sclk;
    logic [1:0] r_mosi;
    logic [1:0] r_cs_n;

    // Free-running so cs_n is already settled when rst drops.
    always_ff @(posedge clk) begin
        r_sclk <= {r_sclk[1:0], sclk};
        r_mosi <= {r_mosi[0], mosi};
        r_cs_n <= {r_cs_n[0], cs_n};
    end

    assign mosi_s   = r_mosi[1];
    assign cs_n_s   = r_cs_n[1];
    assign rise_evt = r_sclk[1] & ~r_sclk[2];
    assign fall_evt = ~r_sclk[1] & r_sclk[2];

endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 responder emulating a small PSRAM
// with READ/WRITE commands and a host side port.
module spi_mem_responder #(
    parameter int MEM_BYTES = 16,
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sclk,
    input  logic                 mosi,
    input  logic                 cs_n,
    output logic                 miso,
    input  logic [ADDR_BITS-1:0] host_addr,
    output logic [7:0]           host_rdata,
    output logic                 busy,
    output logic                 wr_strobe
);
    import spi_mem_pkg::*;

    localparam logic [4:0] ADDR_LAST =
        5'(ADDR_PHASE_BITS - 1);

    logic w_mosi_s;
    logic w_cs_n_s;
    logic w_rise;
    logic w_fall;

    state_t               r_state;
    logic [2:0]           r_bit_cnt;
    logic [4:0]           r_addr_cnt;
    logic                 r_is_read;
    logic                 r_first;
    logic                 r_armed;
    logic                 r_miso;
    logic                 r_busy;
    logic                 r_wr_strobe;
    logic [7:0]           r_shreg;
    logic [ADDR_BITS-1:0] r_ptr;
    logic [7:0]           r_mem [MEM_BYTES];

    logic [7:0]           w_byte_in;
    logic [ADDR_BITS-1:0] w_ptr_in;

    spi_sync_edge u_sync (
        .clk      (clk),
        .sclk     (sclk),
        .mosi     (mosi),
        .cs_n     (cs_n),
        .mosi_s   (w_mosi_s),
        .cs_n_s   (w_cs_n_s),
        .rise_evt (w_rise),
        .fall_evt (w_fall)
    );

    assign w_byte_in = {r_shreg[6:0], w_mosi_s};
    assign w_ptr_in  = {r_ptr[ADDR_BITS-2:0], w_mosi_s};

    // Protocol FSM, shifters and byte array.
    // r_armed blocks a frame that was already
    // running when rst was released.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_addr_cnt  <= '0;
            r_is_read   <= 1'b0;
            r_first     <= 1'b0;
            r_armed     <= 1'b0;
            r_miso      <= 1'b0;
            r_busy      <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_shreg     <= '0;
            r_ptr       <= '0;
            for (int i = 0; i < MEM_BYTES; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_wr_strobe <= 1'b0;
            r_busy      <= ~w_cs_n_s;
            if (w_cs_n_s) begin
                r_state   <= ST_IDLE;
                r_miso    <= 1'b0;
                r_bit_cnt <= '0;
                r_armed   <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_miso     <= 1'b0;
                        r_bit_cnt  <= '0;
                        r_addr_cnt <= '0;
                        if (r_armed) begin
                            r_state <= ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        if (w_rise) begin
                            r_shreg   <= w_byte_in;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                if (w_byte_in == CMD_READ) begin
                                    r_is_read <= 1'b1;
                                    r_state   <= ST_ADDR;
                                end else if (w_byte_in == CMD_WRITE) begin
                                    r_is_read <= 1'b0;
                                    r_state   <= ST_ADDR;
                                end else begin
                                    r_state <= ST_IGNORE;
                                end
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (w_rise) begin
                            r_ptr      <= w_ptr_in;
                            r_addr_cnt <= r_addr_cnt + 5'd1;
                            if (r_addr_cnt == ADDR_LAST) begin
                                r_addr_cnt <= '0;
                                r_bit_cnt  <= '0;
                                if (r_is_read) begin
                                    r_shreg <= r_mem[w_ptr_in];
                                    r_miso  <= r_mem[w_ptr_in][7];
                                    r_ptr   <= w_ptr_in + 1'b1;
                                    r_first <= 1'b1;
                                    r_state <= ST_READ;
                                end else begin
                                    r_state <= ST_WRITE;
                                end
                            end
                        end
                    end
                    ST_READ: begin
                        // Bit 7 went out early; skip the
                        // fall of the last address bit.
                        if (w_fall) begin
                            if (r_first) begin
                                r_first <= 1'b0;
                            end else if (r_bit_cnt == 3'd7) begin
                                r_shreg   <= r_mem[r_ptr];
                                r_miso    <= r_mem[r_ptr][7];
                                r_ptr     <= r_ptr + 1'b1;
                                r_bit_cnt <= '0;
                            end else begin
                                r_shreg   <= {r_shreg[6:0], 1'b0};
                                r_miso    <= r_shreg[6];
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (w_rise) begin
                            r_shreg   <= w_byte_in;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_mem[r_ptr] <= w_byte_in;
                                r_wr_strobe  <= 1'b1;
                                r_ptr        <= r_ptr + 1'b1;
                            end
                        end
                    end
                    ST_IGNORE: begin
                        r_miso <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign miso       = r_miso;
    assign busy       = r_busy;
    assign wr_strobe  = r_wr_strobe;
    assign host_rdata = r_mem[host_addr];

endmodule

// File: tb/tb_spi_mem_responder.sv
// Scoreboard bench for spi_mem_responder: directed
// frames followed by random read/write/abort frames.
module tb_spi_mem_responder;

    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       cs_n = 1'b1;
    logic       miso;
    logic       busy;
    logic       wr_strobe;
    logic [3:0] host_addr = 4'h0;
    logic [7:0] host_rdata;

    int checks = 0;
    int errors = 0;

    logic [7:0] model [16];
    logic [7:0] exp_rd [$];
    logic [7:0] exp_wr [$];
    logic       rd_active = 1'b0;
    logic       chk_zero = 1'b0;

    logic       prev_sclk = 1'b0;
    int         mon_n = 0;
    logic [7:0] mon_byte = 8'h00;
    logic [7:0] mon_e;

    spi_mem_responder #(
        .MEM_BYTES (16),
        .ADDR_BITS (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .mosi       (mosi),
        .cs_n       (cs_n),
        .miso       (miso),
        .host_addr  (host_addr),
        .host_rdata (host_rdata),
        .busy       (busy),
        .wr_strobe  (wr_strobe)
    );

    always #5 clk = ~clk;

    // Monitor: sampled on the falling clk edge.
    always @(negedge clk) begin
        if (!rd_active) begin
            mon_n = 0;
        end else if (sclk && !prev_sclk) begin
            mon_byte = {mon_byte[6:0], miso};
            mon_n++;
            if (mon_n == 8) begin
                mon_n = 0;
                checks++;
                if (exp_rd.size() == 0) begin
                    errors++;
                    $display("FAIL miso_byte: got %h, no byte expected",
                             mon_byte);
                end else begin
                    mon_e = exp_rd.pop_front();
                    if (mon_byte !== mon_e) begin
                        errors++;
                        $display("FAIL miso_byte: got %h, expected %h",
                                 mon_byte, mon_e);
                    end
                end
            end
        end
        prev_sclk = sclk;
        if (chk_zero) begin
            checks++;
            if (miso !== 1'b0) begin
                errors++;
                $display("FAIL miso_zero: got %b, expected 0", miso);
            end
        end
        if (wr_strobe) begin
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL wr_strobe: got pulse, none expected");
            end else begin
                mon_e = exp_wr.pop_front();
                if (host_rdata !== mon_e) begin
                    errors++;
                    $display("FAIL wr_data: got %h, expected %h",
                             host_rdata, mon_e);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check(input string name,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h",
                     name, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        mosi = b;
        tick(HALF);
        sclk = 1'b1;
        tick(HALF);
        sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
        end
    endtask

    task automatic send_addr(input logic [23:0] a);
        send_byte(a[23:16]);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
    endtask

    task automatic frame_begin();
        cs_n = 1'b0;
        tick(HALF);
    endtask

    task automatic frame_end();
        tick(HALF);
        cs_n = 1'b1;
        rd_active = 1'b0;
        chk_zero = 1'b0;
        tick(8);
        check("rd_queue_left", 32'(exp_rd.size()), 32'd0);
        exp_rd.delete();
    endtask

    task automatic check_mem();
        for (int i = 0; i < 16; i++) begin
            host_addr = 4'(i);
            #1;
            check($sformatf("mem[%0d]", i),
                  32'(host_rdata), 32'(model[i]));
        end
    endtask

    task automatic do_write(input logic [23:0] a,
                            input int n,
                            input logic [7:0] d [4]);
        logic [3:0] idx;
        frame_begin();
        send_byte(8'h02);
        send_addr(a);
        for (int k = 0; k < n; k++) begin
            idx = 4'(a[3:0] + 4'(k));
            host_addr = idx;
            model[idx] = d[k];
            exp_wr.push_back(d[k]);
            send_byte(d[k]);
        end
        frame_end();
    endtask

    task automatic do_read(input logic [23:0] a,
                           input int n);
        frame_begin();
        send_byte(8'h03);
        send_addr(a);
        for (int k = 0; k < n; k++) begin
            exp_rd.push_back(model[4'(a[3:0] + 4'(k))]);
        end
        rd_active = 1'b1;
        for (int k = 0; k < n; k++) begin
            send_byte(8'($urandom));
        end
        frame_end();
    endtask

    task automatic do_partial(input logic [23:0] a,
                              input int nbits);
        frame_begin();
        send_byte(8'h02);
        send_addr(a);
        host_addr = a[3:0];
        for (int k = 0; k < nbits; k++) begin
            send_bit(1'($urandom));
        end
        tick(HALF);
        check("busy_in_frame", 32'(busy), 32'd1);
        cs_n = 1'b1;
        tick(3);
        check("busy_fall", 32'(busy), 32'd0);
        tick(8);
    endtask

    logic [7:0] d [4];
    int         op;

    initial begin
        for (int i = 0; i < 16; i++) begin
            model[i] = 8'h00;
        end
        tick(4);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
        check_mem();
        rst = 1'b0;
        tick(6);

        d[0] = 8'hA5; d[1] = 8'h3C; d[2] = 8'h00; d[3] = 8'h00;
        do_write(24'h000003, 2, d);
        check_mem();
        do_read(24'h000003, 2);

        d[0] = 8'h11; d[1] = 8'h22;
        do_write(24'h00000F, 2, d);
        check_mem();
        do_read(24'hFFFF0F, 2);

        frame_begin();
        send_byte(8'h9F);
        chk_zero = 1'b1;
        for (int k = 0; k < 32; k++) begin
            send_bit(1'($urandom));
        end
        frame_end();
        check_mem();
        do_read(24'h000003, 1);

        do_partial(24'h000007, 5);
        check_mem();

        frame_begin();
        send_byte(8'h03);
        for (int k = 0; k < 10; k++) begin
            send_bit(1'b0);
        end
        rst = 1'b1;
        tick(2);
        check("midrst_miso", 32'(miso), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 16; i++) begin
            model[i] = 8'h00;
        end
        check_mem();
        rst = 1'b0;
        chk_zero = 1'b1;
        for (int k = 0; k < 30; k++) begin
            send_bit(1'b1);
        end
        frame_end();
        do_read(24'h000003, 1);

        for (int it = 0; it < 24; it++) begin
            op = int'($urandom_range(0, 2));
            for (int k = 0; k < 4; k++) begin
                d[k] = 8'($urandom);
            end
            if (op == 0) begin
                do_write(24'($urandom),
                         int'($urandom_range(1, 4)), d);
            end else if (op == 1) begin
                do_read(24'($urandom),
                        int'($urandom_range(1, 4)));
            end else begin
                do_partial(24'($urandom),
                           int'($urandom_range(1, 7)));
            end
        end
        check_mem();
        check("wr_queue_left", 32'(exp_wr.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_mem_responder.md
Name: spi_mem_responder

Overview:
SPI-mode-0 responder that emulates a small serial PSRAM, the far end of the existing SPI memory initiator. It decodes READ (0x03) and WRITE (0x02) transactions with a 24-bit address and serves them from an internal byte array. It is used as an on-chip loopback target for controller bring-up and as the device model in bench regressions. The rest of the design can inspect the array through a side read port.

Parameters:
MEM_BYTES, 16, internal array depth in bytes; power of two, 4..256
ADDR_BITS, 4, log2(MEM_BYTES); index = low ADDR_BITS of the received 24-bit address

Ports:
clk  in  1  system clock; all logic is on the rising edge
rst  in  1  synchronous reset, active-high
sclk  in  1  SPI clock from the initiator, asynchronous to clk
mosi  in  1  SPI data from the initiator
cs_n  in  1  chip select, active-low
miso  out  1  SPI data to the initiator
host_addr  in  ADDR_BITS  side-port read index
host_rdata  out  8  mem[host_addr], combinational
busy  out  1  high while cs_n is synchronised low
wr_strobe  out  1  one-clk pulse when a byte is committed to the array

Behaviour:
- Decided: one clock (clk); reset is synchronous and active-high (rst).
- Reset: miso=0, busy=0, wr_strobe=0, state=IDLE, counters=0, array cleared to 0x00.
- Synchronisation:
  - sclk, mosi and cs_n each pass through a 2-flop synchroniser.
  - A third sclk flop gives rise_evt/fall_evt.
  - Sample latency is 3 clk.
  - Requirement: clk >= 8x sclk; each sclk phase lasts >= 4 clk.
- SPI mode 0:
  - mosi is sampled on rise_evt.
  - miso is updated on fall_evt, with one exception: the first data bit is driven on the rise_evt of the final address bit.
- State machine (bit_cnt 0..7, byte-aligned):
  - IDLE: cs_n low -> CMD, with bit_cnt=0.
  - CMD: shift in 8 bits MSB-first. 0x03 -> ADDR(read), 0x02 -> ADDR(write), any other value -> IGNORE.
  - ADDR: shift in 24 bits MSB-first; the pointer is set to addr[ADDR_BITS-1:0]. On the 24th rise_evt:
    - read: load shreg=mem[ptr], miso=mem[ptr][7], ptr++ -> READ.
    - write: -> WRITE.
  - READ: each fall_evt shifts the next bit onto miso. After the 8th bit, the next fall_evt loads mem[ptr] and drives its bit 7, then ptr++. This streams without limit.
  - WRITE: collect 8 bits. On the 8th rise_evt, mem[ptr]<=byte, wr_strobe=1 for that clk, ptr++.
  - IGNORE: miso=0; stay until cs_n goes high.
- Pointer wraps modulo MEM_BYTES (0xF -> 0x0 at default). Upper address bits are ignored.
- cs_n high (synchronised) in any state:
  - Next clk goes to IDLE, miso=0, bit_cnt=0.
  - A partial write byte is discarded; no wr_strobe.
- Simultaneous events:
  - cs_n rising wins over a same-cycle rise_evt or fall_evt.
  - An SPI write and a host_addr read of the same index return the old value in that cycle and the new value from the next cycle.
- miso is 0 outside the READ state. It is never tristated.
- rst mid-transaction returns to IDLE and clears the array. A transfer already in progress is ignored until cs_n is seen high, then low again.
- sclk edges while cs_n is high are ignored.

Decomposition:
- Shared package spi_mem_pkg:
  - CMD_READ=8'h03, CMD_WRITE=8'h02.
  - state encoding IDLE/CMD/ADDR/READ/WRITE/IGNORE (3 bits).
  - ADDR_PHASE_BITS=24.
- Sub-module spi_sync_edge: the 2-flop synchronisers plus sclk edge detect, outputting mosi_s, cs_n_s, rise_evt, fall_evt.
- The FSM, shift registers and array stay in the top module.

Test Plan:
- Write 0x02,000003,A5,3C -> two wr_strobe pulses; host_rdata at addr 3 = 0xA5, at addr 4 = 0x3C; other entries stay 0x00.
- After that write, read 0x03,000003 and clock 16 bits -> miso returns 0xA5 then 0x3C MSB-first; the first bit is valid before the first data rising edge.
- Write 0x02,00000F,11,22 -> mem[15]=0x11 and mem[0]=0x22 (wrap). Then read from 0x0F -> 0x11, 0x22; the upper address bits 0xFFFF00 are ignored.
- Command 0x9F, then 32 further sclk cycles -> miso stays 0, no wr_strobe, array unchanged; next frame 0x03,000003 -> 0xA5.
- Write frame with only 5 data bits before cs_n rises -> no wr_strobe, target byte unchanged, busy falls within 3 clk.
- Assert rst in the middle of the address phase -> miso=0, busy=0, all host_rdata=0x00. A following clean read returns 0x00.
